// File: rtl/traffic_conflict_monitor_pkg.sv
// Shared types and default phase timings for the traffic controller and its conflict monitor.
package traffic_conflict_monitor_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    FC_NONE          = 3'd0,
    FC_ILLEGAL_TRANS = 3'd1,
    FC_PREMATURE     = 3'd2,
    FC_BAD_LOAD      = 3'd3,
    FC_BAD_DECR      = 3'd4,
    FC_RANGE         = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    MON_INIT  = 2'd0,
    MON_RUN   = 2'd1,
    MON_FAULT = 2'd2
  } mon_state_e;

  localparam int unsigned DEF_TIME_S0    = 30;
  localparam int unsigned DEF_TIME_S1    = 5;
  localparam int unsigned DEF_TIME_S2    = 30;
  localparam int unsigned DEF_TIME_S3    = 5;
  localparam int unsigned DEF_FLASH_HALF = 8;

endpackage

// File: rtl/traffic_conflict_monitor_flash_divider.sv
// Failsafe flash generator: drives 1 on enable, then toggles every HALF cycles while enabled.
module flash_divider #(
  parameter int unsigned HALF = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic flash_o
);

  localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          flash_q, flash_d;
  logic          active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    flash_d  = flash_q;
    active_d = active_q;
    if (!en_i) begin
      cnt_d    = '0;
      flash_d  = 1'b0;
      active_d = 1'b0;
    end else if (!active_q) begin
      // First enabled cycle: start lit with a fresh half-period.
      cnt_d    = '0;
      flash_d  = 1'b1;
      active_d = 1'b1;
    end else if (cnt_q == CW'(HALF - 1)) begin
      cnt_d   = '0;
      flash_d = ~flash_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      flash_q  <= 1'b0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      flash_q  <= flash_d;
      active_q <= active_d;
    end
  end

  assign flash_o = flash_q;

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Watches a traffic controller's phase/countdown and latches the first protocol violation.
module traffic_conflict_monitor
  import traffic_conflict_monitor_pkg::*;
#(
  parameter int unsigned TIME_S0    = DEF_TIME_S0,
  parameter int unsigned TIME_S1    = DEF_TIME_S1,
  parameter int unsigned TIME_S2    = DEF_TIME_S2,
  parameter int unsigned TIME_S3    = DEF_TIME_S3,
  parameter int unsigned FLASH_HALF = DEF_FLASH_HALF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] state,
  input  logic [5:0] timer,
  input  logic       clr_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash,
  output logic [7:0] fault_count
);

  function automatic logic [5:0] load_of(input phase_e p);
    logic [5:0] v;
    case (p)
      S0:      v = 6'(TIME_S0);
      S1:      v = 6'(TIME_S1);
      S2:      v = 6'(TIME_S2);
      default: v = 6'(TIME_S3);
    endcase
    return v;
  endfunction

  mon_state_e  mon_q, mon_d;
  fault_code_e code_q, code_d, viol;
  logic [7:0]  count_q, count_d;
  logic [1:0]  prev_state_q;
  logic [5:0]  prev_timer_q;
  logic [5:0]  load_cur;
  logic        same, adv, fault_next;

  assign load_cur = load_of(phase_e'(state));
  assign same     = (state == prev_state_q);
  assign adv      = (state == prev_state_q + 2'd1);

  // Priority chain yields the lowest-numbered cause; the decrement compare is
  // only reached with prev_timer_q != 0, so it never wraps.
  always_comb begin
    viol = FC_NONE;
    if (mon_q == MON_INIT) begin
      if (timer > load_cur) viol = FC_RANGE;
    end else if (mon_q == MON_RUN) begin
      if (!same && !adv)
        viol = FC_ILLEGAL_TRANS;
      else if ((same && prev_timer_q == '0) || (adv && prev_timer_q != '0))
        viol = FC_PREMATURE;
      else if (adv && timer != load_cur)
        viol = FC_BAD_LOAD;
      else if (same && timer != prev_timer_q - 6'd1)
        viol = FC_BAD_DECR;
      else if (timer > load_cur)
        viol = FC_RANGE;
    end
  end

  always_comb begin
    mon_d   = mon_q;
    code_d  = code_q;
    count_d = count_q;
    case (mon_q)
      MON_INIT, MON_RUN: begin
        if (viol != FC_NONE) begin
          mon_d  = MON_FAULT;
          code_d = viol;
          if (count_q != '1) count_d = count_q + 8'd1;
        end else begin
          mon_d = MON_RUN;
        end
      end
      MON_FAULT: begin
        if (clr_fault) begin
          mon_d  = MON_INIT;
          code_d = FC_NONE;
        end
      end
      default: mon_d = MON_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_q        <= MON_INIT;
      code_q       <= FC_NONE;
      count_q      <= '0;
      prev_state_q <= '0;
      prev_timer_q <= '0;
    end else begin
      mon_q        <= mon_d;
      code_q       <= code_d;
      count_q      <= count_d;
      prev_state_q <= state;
      prev_timer_q <= timer;
    end
  end

  assign fault_next = (mon_d == MON_FAULT);

  flash_divider #(
    .HALF(FLASH_HALF)
  ) u_flash (
    .clk    (clk),
    .rst    (rst),
    .en_i   (fault_next),
    .flash_o(flash)
  );

  assign fault       = (mon_q == MON_FAULT);
  assign fault_code  = code_q;
  assign fault_count = count_q;

endmodule

// File: doc/traffic_conflict_monitor.md
TRAFFIC_CONFLICT_MONITOR -- requirements
Module: traffic_conflict_monitor

Interface
REQ-001 Parameter TIME_S0, default 30, is the phase-0 load value (main green).
REQ-002 Parameter TIME_S1, default 5, is the phase-1 load value (main yellow).
REQ-003 Parameter TIME_S2, default 30, is the phase-2 load value (side green).
REQ-004 Parameter TIME_S3, default 5, is the phase-3 load value (side yellow).
REQ-005 Parameter FLASH_HALF, default 8, is the failsafe flash half-period in clk cycles.
REQ-006 clk  input  1  clock; all logic on rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 state  input  2  controller phase under observation (0..3).
REQ-009 timer  input  6  controller countdown under observation.
REQ-010 clr_fault  input  1  operator clear; single-cycle pulse.
REQ-011 fault  output  1  sticky fault flag.
REQ-012 fault_code  output  3  cause of the latched fault; 0 = none.
REQ-013 flash  output  1  failsafe all-red flash drive.
REQ-014 fault_count  output  8  saturating count of fault entries.

Function
REQ-015 Monitor FSM SHALL have states INIT, RUN and FAULT.
REQ-016 state and timer SHALL be sampled every edge, and the previous sample SHALL be held in prev_state/prev_timer.
REQ-017 In INIT, one sample SHALL be captured and checked only for range: timer > load(state) -> FAULT with code 5; otherwise -> RUN.
REQ-018 In RUN, the hold rule applies when state == prev_state: timer SHALL equal prev_timer-1; a violation gives code 4, and the same state with prev_timer == 0 gives code 2.
REQ-019 In RUN, the advance rule applies when state == prev_state+1 mod 4 (3->0 wraps): prev_timer SHALL be 0, else code 2; the new timer SHALL equal load(state), else code 3.
REQ-020 In RUN, any other state change (skip or backward) SHALL give code 1.
REQ-021 In RUN, timer > load(state) SHALL give code 5.
REQ-022 Simultaneous violations SHALL report the lowest code: 1 > 2 > 3 > 4 > 5.
REQ-023 Any violation SHALL move the FSM to FAULT with fault=1 and fault_code set, registered on the edge that samples the offending value (visible one cycle after the value is presented).
REQ-024 In FAULT, further violations SHALL be ignored, and fault_code SHALL hold the first cause.
REQ-025 In FAULT, clr_fault=1 SHALL move the FSM to INIT and clear fault and fault_code on that edge; clear SHALL win over a same-cycle violation.
REQ-026 clr_fault SHALL be ignored in INIT and RUN.
REQ-027 Flash behaviour:
- flash SHALL be 1 on FAULT entry.
- flash SHALL toggle every FLASH_HALF cycles while in FAULT.
- flash SHALL be 0 outside FAULT.
REQ-028 fault_count SHALL increment on each RUN/INIT->FAULT transition, saturate at 255, and be unaffected by clr_fault.
REQ-029 load(state) arithmetic SHALL be 6-bit unsigned, and the prev_timer-1 comparison SHALL NOT wrap (prev_timer == 0 is handled by REQ-018).

Reset
REQ-030 rst SHALL force INIT with fault=0, fault_code=0, flash=0, fault_count=0, the flash counter at 0, and prev_state/prev_timer at 0.
REQ-031 rst asserted mid-FAULT or mid-RUN SHALL take effect immediately and discard the latched cause.

Structure
REQ-032 A shared package SHALL hold the phase enum (S0..S3), the fault-code enum (NONE, ILLEGAL_TRANS, PREMATURE, BAD_LOAD, BAD_DECR, RANGE) and the default phase timings, also used by the controller.
REQ-033 The flash divider SHALL be a sub-module, flash_divider, enabled by FAULT.

Verification
REQ-034 Drive the legal sequence from reset (s0/30 down to 0, s1/5, s2/30, s3/5, back to s0/30) for two full cycles -> fault stays 0 and fault_count stays 0.
REQ-035 In s0 at timer=12, drive timer=10 -> next cycle fault=1, code=4, flash=1, fault_count=1.
REQ-036 Drive the s1->s3 jump while also presenting timer=40 -> code=1, because priority selects illegal transition over range.
REQ-037 Drive s0 timer=3 followed by s1 timer=5 -> code=2; after FAULT entry, flash toggles after 8 cycles and again after 16.
REQ-038 Pulse clr_fault while in FAULT together with a new violation -> fault=0, code=0, INIT; next sample s2/7 -> RUN with no fault.
REQ-039 Induce 256 fault/clear cycles -> fault_count=255; assert rst mid-FAULT -> all outputs 0 immediately.
